core_control_fsm: RTL and testbench

//  Multicycle RV32I control sequencer that drives the core control-signal bundle.

---
 rtl/core_control_fsm_if.sv | 64 ++++++
 rtl/core_control_fsm.sv | 263 ++++++++++++++++++++++++++
 tb/tb_core_control_fsm.sv | 346 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/core_control_fsm_if.sv
// core_control_fsm_if
//   Control bundle between the multicycle control sequencer and the
//   decoder / memory / datapath side.
//   master : the sequencer (reads status, drives enables/selects)
//   slave  : decoder, memory and datapath (drive status, read enables)
//   Status : opcode, invalid_inst, ialign, mem_complete_read,
//            mem_complete_write, mem_malign
//   Control: write_pc, write_ir, write_rd, mem_read, mem_write, addr_sel,
//            rd_sel, alu_insel1, alu_insel2, trap, trap_cause, state
//   CORE_CONTROL_DEBUG_HALT_EN adds halt_req, resume_req (status side) and
//   halted (control side).
interface core_control_fsm_if #(
  parameter int OPCODE_WIDTH = 7
);
  logic [OPCODE_WIDTH-1:0] opcode;
  logic                    invalid_inst;
  logic                    ialign;
  logic                    mem_complete_read;
  logic                    mem_complete_write;
  logic                    mem_malign;
  logic                    write_pc;
  logic                    write_ir;
  logic                    write_rd;
  logic                    mem_read;
  logic                    mem_write;
  logic                    addr_sel;
  logic                    rd_sel;
  logic [1:0]              alu_insel1;
  logic [1:0]              alu_insel2;
  logic                    trap;
  logic [1:0]              trap_cause;
  logic [2:0]              state;
`ifdef CORE_CONTROL_DEBUG_HALT_EN
  logic                    halt_req;
  logic                    resume_req;
  logic                    halted;

  modport master (
    input  opcode, invalid_inst, ialign, mem_complete_read,
           mem_complete_write, mem_malign, halt_req, resume_req,
    output write_pc, write_ir, write_rd, mem_read, mem_write, addr_sel,
           rd_sel, alu_insel1, alu_insel2, trap, trap_cause, state, halted
  );
  modport slave (
    output opcode, invalid_inst, ialign, mem_complete_read,
           mem_complete_write, mem_malign, halt_req, resume_req,
    input  write_pc, write_ir, write_rd, mem_read, mem_write, addr_sel,
           rd_sel, alu_insel1, alu_insel2, trap, trap_cause, state, halted
  );
`else
  modport master (
    input  opcode, invalid_inst, ialign, mem_complete_read,
           mem_complete_write, mem_malign,
    output write_pc, write_ir, write_rd, mem_read, mem_write, addr_sel,
           rd_sel, alu_insel1, alu_insel2, trap, trap_cause, state
  );
  modport slave (
    output opcode, invalid_inst, ialign, mem_complete_read,
           mem_complete_write, mem_malign,
    input  write_pc, write_ir, write_rd, mem_read, mem_write, addr_sel,
           rd_sel, alu_insel1, alu_insel2, trap, trap_cause, state
  );
`endif
endinterface

// File: rtl/core_control_fsm.sv
// core_control_fsm
//   Multicycle RV32I control sequencer. Steps FETCH/DECODE/EXEC/MEM/WB and
//   raises traps on illegal instructions, misaligned targets, misaligned
//   data accesses and bus timeouts. A watchdog bounds every wait on memory.
//   Ports:
//     clk   : core clock
//     rst_n : asynchronous active-low reset; request strobes drop at once
//     ctl   : core_control_fsm_if.master control/status bundle
//   Optional feature macro: CORE_CONTROL_DEBUG_HALT_EN adds debug halt and
//   resume at instruction boundaries (HALT state, halt_req/resume_req/halted).
//
//   state  | meaning
//   FETCH  | read instruction at PC, latch IR on completion
//   DECODE | decoder settles, illegal instruction check
//   EXEC   | ALU op / PC update, or address setup for LOAD/STORE
//   MEM    | data access at ALU address, request held until complete
//   WB     | write load data to rd, advance PC
//   TRAP   | one-cycle trap pulse, PC loads trap vector
//   HALT   | debug halt between instructions (debug builds only)
module core_control_fsm #(
  parameter int OPCODE_WIDTH  = 7,
  parameter int TIMEOUT_WIDTH = 8,
  parameter int MEM_TIMEOUT   = 255
) (
  input logic               clk,
  input logic               rst_n,
  core_control_fsm_if.master ctl
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  localparam logic [OPCODE_WIDTH-1:0] OPC_LOAD   = OPCODE_WIDTH'(7'b0000011);
  localparam logic [OPCODE_WIDTH-1:0] OPC_MISC   = OPCODE_WIDTH'(7'b0001111);
  localparam logic [OPCODE_WIDTH-1:0] OPC_OPIMM  = OPCODE_WIDTH'(7'b0010011);
  localparam logic [OPCODE_WIDTH-1:0] OPC_AUIPC  = OPCODE_WIDTH'(7'b0010111);
  localparam logic [OPCODE_WIDTH-1:0] OPC_STORE  = OPCODE_WIDTH'(7'b0100011);
  localparam logic [OPCODE_WIDTH-1:0] OPC_OP     = OPCODE_WIDTH'(7'b0110011);
  localparam logic [OPCODE_WIDTH-1:0] OPC_LUI    = OPCODE_WIDTH'(7'b0110111);
  localparam logic [OPCODE_WIDTH-1:0] OPC_BRANCH = OPCODE_WIDTH'(7'b1100011);
  localparam logic [OPCODE_WIDTH-1:0] OPC_JALR   = OPCODE_WIDTH'(7'b1100111);
  localparam logic [OPCODE_WIDTH-1:0] OPC_JAL    = OPCODE_WIDTH'(7'b1101111);
  localparam logic [OPCODE_WIDTH-1:0] OPC_SYSTEM = OPCODE_WIDTH'(7'b1110011);

  // Counter value seen during the last permitted wait cycle.
  localparam logic [TIMEOUT_WIDTH-1:0] WD_LAST =
    TIMEOUT_WIDTH'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  state_t                   state_q, state_d, fetch_tgt;
  logic [1:0]               cause_q, cause_d;
  logic [TIMEOUT_WIDTH-1:0] wd_q, wd_d;
  logic                     wd_expired;
  logic                     is_load, is_store;

  assign is_load    = (ctl.opcode == OPC_LOAD);
  assign is_store   = (ctl.opcode == OPC_STORE);
  assign wd_expired = (MEM_TIMEOUT != 0) && (wd_q == WD_LAST);

`ifdef CORE_CONTROL_DEBUG_HALT_EN
  // Set during reset so that reset exit also counts as entering FETCH.
  logic boot_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) boot_q <= 1'b1;
    else        boot_q <= 1'b0;
  end

  assign fetch_tgt = ctl.halt_req ? S_HALT : S_FETCH;
`else
  assign fetch_tgt = S_FETCH;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      cause_q <= 2'd0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      wd_q    <= wd_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    cause_d        = cause_q;
    ctl.write_pc   = 1'b0;
    ctl.write_ir   = 1'b0;
    ctl.write_rd   = 1'b0;
    ctl.mem_read   = 1'b0;
    ctl.mem_write  = 1'b0;
    ctl.addr_sel   = 1'b0;
    ctl.rd_sel     = 1'b0;
    ctl.alu_insel1 = 2'd0;
    ctl.alu_insel2 = 2'd0;
    ctl.trap       = 1'b0;
`ifdef CORE_CONTROL_DEBUG_HALT_EN
    ctl.halted     = 1'b0;
`endif

    case (state_q)
      S_FETCH: begin
`ifdef CORE_CONTROL_DEBUG_HALT_EN
        if (boot_q && ctl.halt_req) begin
          state_d = S_HALT;
        end else
`endif
        begin
          ctl.mem_read = 1'b1;
          if (ctl.mem_malign) begin
            state_d = S_TRAP;
            cause_d = 2'd1;
          end else if (ctl.mem_complete_read) begin
            ctl.write_ir = 1'b1;
            state_d      = S_DECODE;
          end else if (wd_expired) begin
            state_d = S_TRAP;
            cause_d = 2'd3;
          end
        end
      end

      S_DECODE: begin
        if (ctl.invalid_inst) begin
          state_d = S_TRAP;
          cause_d = 2'd0;
        end else begin
          state_d = S_EXEC;
        end
      end

      S_EXEC: begin
        case (ctl.opcode)
          OPC_OP, OPC_OPIMM: begin
            ctl.alu_insel2 = (ctl.opcode == OPC_OPIMM) ? 2'd1 : 2'd0;
            ctl.write_rd   = 1'b1;
            ctl.write_pc   = 1'b1;
            state_d        = fetch_tgt;
          end
          OPC_LUI, OPC_AUIPC: begin
            ctl.alu_insel1 = (ctl.opcode == OPC_LUI) ? 2'd2 : 2'd1;
            ctl.alu_insel2 = 2'd1;
            ctl.write_rd   = 1'b1;
            ctl.write_pc   = 1'b1;
            state_d        = fetch_tgt;
          end
          OPC_JAL, OPC_JALR: begin
            ctl.alu_insel1 = 2'd1;
            ctl.alu_insel2 = 2'd2;
            if (ctl.ialign) begin
              state_d = S_TRAP;
              cause_d = 2'd1;
            end else begin
              ctl.write_rd = 1'b1;
              ctl.write_pc = 1'b1;
              state_d      = fetch_tgt;
            end
          end
          OPC_BRANCH: begin
            if (ctl.ialign) begin
              state_d = S_TRAP;
              cause_d = 2'd1;
            end else begin
              ctl.write_pc = 1'b1;
              state_d      = fetch_tgt;
            end
          end
          OPC_MISC, OPC_SYSTEM: begin
            ctl.write_pc = 1'b1;
            state_d      = fetch_tgt;
          end
          OPC_LOAD, OPC_STORE: begin
            state_d = S_MEM;
          end
          // Opcodes the decoder let through but we cannot sequence.
          default: begin
            state_d = S_TRAP;
            cause_d = 2'd0;
          end
        endcase
      end

      S_MEM: begin
        ctl.addr_sel   = 1'b1;
        ctl.alu_insel2 = 2'd1;
        ctl.mem_read   = is_load;
        ctl.mem_write  = is_store;
        if (ctl.mem_malign) begin
          state_d = S_TRAP;
          cause_d = 2'd2;
        end else if (is_load && ctl.mem_complete_read) begin
          state_d = S_WB;
        end else if (is_store && ctl.mem_complete_write) begin
          ctl.write_pc = 1'b1;
          state_d      = fetch_tgt;
        end else if (wd_expired) begin
          state_d = S_TRAP;
          cause_d = 2'd3;
        end
      end

      S_WB: begin
        ctl.write_rd = 1'b1;
        ctl.rd_sel   = 1'b1;
        ctl.write_pc = 1'b1;
        state_d      = fetch_tgt;
      end

      S_TRAP: begin
        ctl.trap     = 1'b1;
        ctl.write_pc = 1'b1;
        state_d      = fetch_tgt;
      end

      S_HALT: begin
`ifdef CORE_CONTROL_DEBUG_HALT_EN
        ctl.halted = 1'b1;
        if (ctl.resume_req) state_d = S_FETCH;
`else
        state_d = S_FETCH;
`endif
      end

      default: state_d = S_FETCH;
    endcase

    // Strobes must fall the moment reset asserts, not at the next edge.
    if (!rst_n) begin
      ctl.write_pc   = 1'b0;
      ctl.write_ir   = 1'b0;
      ctl.write_rd   = 1'b0;
      ctl.mem_read   = 1'b0;
      ctl.mem_write  = 1'b0;
      ctl.addr_sel   = 1'b0;
      ctl.rd_sel     = 1'b0;
      ctl.alu_insel1 = 2'd0;
      ctl.alu_insel2 = 2'd0;
      ctl.trap       = 1'b0;
`ifdef CORE_CONTROL_DEBUG_HALT_EN
      ctl.halted     = 1'b0;
`endif
    end
  end

  // Counts consecutive wait cycles; any state change restarts it.
  always_comb begin
    wd_d = '0;
    if ((state_q == S_FETCH || state_q == S_MEM) && state_d == state_q)
      wd_d = wd_q + TIMEOUT_WIDTH'(1);
  end

  assign ctl.trap_cause = cause_q;
  assign ctl.state      = state_q;

endmodule

// File: tb/tb_core_control_fsm.sv
module tb_core_control_fsm;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_MISC   = 7'b0001111;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef struct packed {
    logic [2:0] st;
    logic       wpc, wir, wrd, mrd, mwr, asel, rsel;
    logic [1:0] i1, i2;
    logic       tr;
    logic [1:0] tc;
    logic       hl;
  } ctl_t;

  typedef struct {
    string name;
    ctl_t  exp;
  } sb_t;

  typedef struct {
    logic [6:0] op;
    logic [1:0] i1, i2;
    logic       wrd, wpc;
    string      nm;
  } ex_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  core_control_fsm_if #(.OPCODE_WIDTH(7)) bus ();

  core_control_fsm #(
    .OPCODE_WIDTH (7),
    .TIMEOUT_WIDTH(8),
    .MEM_TIMEOUT  (4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .ctl  (bus)
  );

  sb_t        sb_q[$];
  int         checks   = 0;
  int         failures = 0;
  logic [1:0] cause_m  = 2'd0;
  sb_t        mon_s;
  ctl_t       mon_a;
  ex_t        tbl[8];

  function automatic ctl_t actual();
    ctl_t r;
    r.st   = bus.state;
    r.wpc  = bus.write_pc;
    r.wir  = bus.write_ir;
    r.wrd  = bus.write_rd;
    r.mrd  = bus.mem_read;
    r.mwr  = bus.mem_write;
    r.asel = bus.addr_sel;
    r.rsel = bus.rd_sel;
    r.i1   = bus.alu_insel1;
    r.i2   = bus.alu_insel2;
    r.tr   = bus.trap;
    r.tc   = bus.trap_cause;
`ifdef CORE_CONTROL_DEBUG_HALT_EN
    r.hl   = bus.halted;
`else
    r.hl   = 1'b0;
`endif
    return r;
  endfunction

  // Expected-value builders; trap_cause follows the bench's own sticky copy.
  function automatic ctl_t mk(input logic [2:0] st);
    ctl_t r;
    r    = '0;
    r.st = st;
    r.tc = cause_m;
    return r;
  endfunction

  function automatic ctl_t x_reset();
    return '0;
  endfunction

  function automatic ctl_t x_fetch(input logic done);
    ctl_t r = mk(3'd0);
    r.mrd = 1'b1;
    r.wir = done;
    return r;
  endfunction

  function automatic ctl_t x_decode();
    return mk(3'd1);
  endfunction

  function automatic ctl_t x_exec(input logic [1:0] i1, input logic [1:0] i2,
                                  input logic wrd, input logic wpc);
    ctl_t r = mk(3'd2);
    r.i1  = i1;
    r.i2  = i2;
    r.wrd = wrd;
    r.wpc = wpc;
    return r;
  endfunction

  function automatic ctl_t x_mem(input logic ld, input logic wpc);
    ctl_t r = mk(3'd3);
    r.asel = 1'b1;
    r.i2   = 2'd1;
    r.mrd  = ld;
    r.mwr  = ~ld;
    r.wpc  = wpc;
    return r;
  endfunction

  function automatic ctl_t x_wb();
    ctl_t r = mk(3'd4);
    r.wrd  = 1'b1;
    r.rsel = 1'b1;
    r.wpc  = 1'b1;
    return r;
  endfunction

  function automatic ctl_t x_trap(input logic [1:0] c);
    ctl_t r;
    cause_m = c;
    r       = mk(3'd5);
    r.tr    = 1'b1;
    r.wpc   = 1'b1;
    return r;
  endfunction

  task automatic set_in(input logic [6:0] op, input logic inv, input logic ia,
                        input logic cr, input logic cw, input logic ma);
    bus.opcode             = op;
    bus.invalid_inst       = inv;
    bus.ialign             = ia;
    bus.mem_complete_read  = cr;
    bus.mem_complete_write = cw;
    bus.mem_malign         = ma;
  endtask

  // Expected response for the current cycle is queued, then one clock passes.
  task automatic step(input string name, input ctl_t e);
    sb_t s;
    s.name = name;
    s.exp  = e;
    sb_q.push_back(s);
    @(posedge clk);
    #1;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (sb_q.size() != 0) begin
        mon_s = sb_q.pop_front();
        mon_a = actual();
        checks++;
        if (mon_a !== mon_s.exp) begin
          failures++;
          $display("FAIL %s actual=%h required=%h", mon_s.name, mon_a, mon_s.exp);
        end
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL tb_timeout actual=running required=finished");
    $fatal(1, "time limit");
  end

  initial begin
    tbl[0] = '{OPC_OP,     2'd0, 2'd0, 1'b1, 1'b1, "exec_op"};
    tbl[1] = '{OPC_LUI,    2'd2, 2'd1, 1'b1, 1'b1, "exec_lui"};
    tbl[2] = '{OPC_AUIPC,  2'd1, 2'd1, 1'b1, 1'b1, "exec_auipc"};
    tbl[3] = '{OPC_JAL,    2'd1, 2'd2, 1'b1, 1'b1, "exec_jal"};
    tbl[4] = '{OPC_JALR,   2'd1, 2'd2, 1'b1, 1'b1, "exec_jalr"};
    tbl[5] = '{OPC_BRANCH, 2'd0, 2'd0, 1'b0, 1'b1, "exec_branch"};
    tbl[6] = '{OPC_MISC,   2'd0, 2'd0, 1'b0, 1'b1, "exec_fence"};
    tbl[7] = '{OPC_SYSTEM, 2'd0, 2'd0, 1'b0, 1'b1, "exec_system"};

    rst_n = 1'b0;
    set_in(OPC_OPIMM, 0, 0, 0, 0, 0);
`ifdef CORE_CONTROL_DEBUG_HALT_EN
    bus.halt_req   = 1'b0;
    bus.resume_req = 1'b0;
`endif
    @(posedge clk);
    #1;
    step("reset_0", x_reset());
    step("reset_1", x_reset());
    rst_n = 1'b1;

    // ADDI, fetch completes after two waits
    step("addi_f1", x_fetch(0));
    step("addi_f2", x_fetch(0));
    set_in(OPC_OPIMM, 0, 0, 1, 0, 0);
    step("addi_f3", x_fetch(1));
    set_in(OPC_OPIMM, 0, 0, 0, 0, 0);
    step("addi_dec", x_decode());
    step("addi_exec", x_exec(2'd0, 2'd1, 1, 1));

    // LW, read completes one cycle into MEM
    set_in(OPC_LOAD, 0, 0, 1, 0, 0);
    step("lw_f", x_fetch(1));
    set_in(OPC_LOAD, 0, 0, 0, 0, 0);
    step("lw_dec", x_decode());
    step("lw_exec", x_exec(2'd0, 2'd0, 0, 0));
    step("lw_mem1", x_mem(1, 0));
    set_in(OPC_LOAD, 0, 0, 1, 0, 0);
    step("lw_mem2", x_mem(1, 0));
    set_in(OPC_LOAD, 0, 0, 0, 0, 0);
    step("lw_wb", x_wb());

    // SW, write accepted first MEM cycle
    set_in(OPC_STORE, 0, 0, 1, 0, 0);
    step("sw_f", x_fetch(1));
    set_in(OPC_STORE, 0, 0, 0, 0, 0);
    step("sw_dec", x_decode());
    step("sw_exec", x_exec(2'd0, 2'd0, 0, 0));
    set_in(OPC_STORE, 0, 0, 0, 1, 0);
    step("sw_mem", x_mem(0, 1));

    // SW misaligned, completion in the same cycle loses
    set_in(OPC_STORE, 0, 0, 1, 0, 0);
    step("swm_f", x_fetch(1));
    set_in(OPC_STORE, 0, 0, 0, 0, 0);
    step("swm_dec", x_decode());
    step("swm_exec", x_exec(2'd0, 2'd0, 0, 0));
    set_in(OPC_STORE, 0, 0, 0, 1, 1);
    step("swm_mem", x_mem(0, 0));
    set_in(OPC_STORE, 0, 0, 0, 0, 0);
    step("swm_trap", x_trap(2'd2));

    // Fetch watchdog expiry at the fourth wait cycle
    set_in(OPC_OPIMM, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step("fto_wait", x_fetch(0));
    step("fto_trap", x_trap(2'd3));

    // Completion on the fourth wait cycle beats the watchdog
    for (int i = 0; i < 3; i++) step("fok_wait", x_fetch(0));
    set_in(OPC_OPIMM, 0, 0, 1, 0, 0);
    step("fok_done", x_fetch(1));
    set_in(OPC_OPIMM, 0, 0, 0, 0, 0);
    step("fok_dec", x_decode());
    step("fok_exec", x_exec(2'd0, 2'd1, 1, 1));

    // LW watchdog expiry in MEM
    set_in(OPC_LOAD, 0, 0, 1, 0, 0);
    step("mto_f", x_fetch(1));
    set_in(OPC_LOAD, 0, 0, 0, 0, 0);
    step("mto_dec", x_decode());
    step("mto_exec", x_exec(2'd0, 2'd0, 0, 0));
    for (int i = 0; i < 4; i++) step("mto_wait", x_mem(1, 0));
    step("mto_trap", x_trap(2'd3));

    // JAL with misaligned target
    set_in(OPC_JAL, 0, 0, 1, 0, 0);
    step("jal_f", x_fetch(1));
    set_in(OPC_JAL, 0, 0, 0, 0, 0);
    step("jal_dec", x_decode());
    set_in(OPC_JAL, 0, 1, 0, 0, 0);
    step("jal_exec", x_exec(2'd1, 2'd2, 0, 0));
    set_in(OPC_JAL, 0, 0, 0, 0, 0);
    step("jal_trap", x_trap(2'd1));

    // Illegal instruction
    set_in(OPC_OPIMM, 0, 0, 1, 0, 0);
    step("ill_f", x_fetch(1));
    set_in(OPC_OPIMM, 1, 0, 0, 0, 0);
    step("ill_dec", x_decode());
    set_in(OPC_OPIMM, 0, 0, 0, 0, 0);
    step("ill_trap", x_trap(2'd0));

    // Misaligned fetch beats a same-cycle completion
    set_in(OPC_OPIMM, 0, 0, 1, 0, 1);
    step("fmal_f", x_fetch(0));
    set_in(OPC_OPIMM, 0, 0, 0, 0, 0);
    step("fmal_trap", x_trap(2'd1));

    // EXEC decoding across opcode classes
    for (int i = 0; i < 8; i++) begin
      set_in(tbl[i].op, 0, 0, 1, 0, 0);
      step("tbl_f", x_fetch(1));
      set_in(tbl[i].op, 0, 0, 0, 0, 0);
      step("tbl_dec", x_decode());
      step(tbl[i].nm, x_exec(tbl[i].i1, tbl[i].i2, tbl[i].wrd, tbl[i].wpc));
    end

    // Reset asserted mid-load: strobes drop before any clock edge
    set_in(OPC_LOAD, 0, 0, 1, 0, 0);
    step("rmid_f", x_fetch(1));
    set_in(OPC_LOAD, 0, 0, 0, 0, 0);
    step("rmid_dec", x_decode());
    step("rmid_exec", x_exec(2'd0, 2'd0, 0, 0));
    step("rmid_mem", x_mem(1, 0));
    rst_n   = 1'b0;
    cause_m = 2'd0;
    step("rmid_rst", x_reset());
    rst_n = 1'b1;
    set_in(OPC_OPIMM, 0, 0, 0, 0, 0);
    step("rmid_refetch", x_fetch(0));

`ifdef CORE_CONTROL_DEBUG_HALT_EN
    // Halt requested during EXEC of ADDI, then resume with halt still high
    set_in(OPC_OPIMM, 0, 0, 1, 0, 0);
    step("dbg_f", x_fetch(1));
    set_in(OPC_OPIMM, 0, 0, 0, 0, 0);
    step("dbg_dec", x_decode());
    bus.halt_req = 1'b1;
    step("dbg_exec", x_exec(2'd0, 2'd1, 1, 1));
    begin
      ctl_t h = mk(3'd6);
      h.hl = 1'b1;
      step("dbg_halt1", h);
      bus.resume_req = 1'b1;
      step("dbg_halt2", h);
    end
    bus.halt_req   = 1'b0;
    bus.resume_req = 1'b0;
    step("dbg_resume", x_fetch(0));
`endif

    repeat (2) @(negedge clk);
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL sb_drain actual=%0d required=0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
